// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring integer divider, one quotient bit per clock.
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
//   defined   -> two's complement operands (truncating division, remainder follows dividend)
//   undefined -> unsigned operands
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request, sampled only while idle
//   dividend     N-bit dividend, captured on the accepting edge
//   divisor      N-bit divisor, captured on the accepting edge
//   busy         high while an operation is in flight
//   done         one-cycle pulse when results are written
//   quotient     result quotient, held until the next accepted start
//   remainder    result remainder, held until the next accepted start
//   div_by_zero  set with done when the divisor was zero
module seq_divider #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q, state_d;
  logic            accept;
  logic            divisor_zero;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]    rem_q;   // partial remainder
  logic [N-1:0]    dvd_q;   // dividend bits shift out, quotient bits shift in
  logic [N-1:0]    dsr_q;   // divisor magnitude
  logic            dz_q;

  logic [N-1:0]    a_mag, b_mag;
  logic [N:0]      shifted, diff;
  logic [N-1:0]    q_res, r_res;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic            qneg_q, rneg_q;
`endif

  assign divisor_zero = (divisor == '0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = divisor_zero ? StFix : StRun;
        end
      end
      StRun:   if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand magnitudes taken at acceptance
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    a_mag = dividend[N-1] ? ('0 - dividend) : dividend;
    b_mag = divisor[N-1]  ? ('0 - divisor)  : divisor;
`else
    a_mag = dividend;
    b_mag = divisor;
`endif
  end

  // Trial subtraction: rem_q < dsr_q always holds, so bit N of diff is the borrow.
  always_comb begin
    shifted = {rem_q, dvd_q[N-1]};
    diff    = shifted - {1'b0, dsr_q};
  end

  // Result formation for writeback
  always_comb begin
    if (dz_q) begin
      q_res = '1;
      r_res = dvd_q;  // raw dividend was stored for this case
    end else begin
      q_res = dvd_q;
      r_res = rem_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (qneg_q) q_res = '0 - dvd_q;
      if (rneg_q) r_res = '0 - rem_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      dz_q        <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy  <= 1'b1;
        cnt_q <= CntW'(N - 1);
        rem_q <= '0;
        dsr_q <= b_mag;
        dz_q  <= divisor_zero;
        dvd_q <= divisor_zero ? dividend : a_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
        qneg_q <= dividend[N-1] ^ divisor[N-1];
        rneg_q <= dividend[N-1];
`endif
      end else if (state_q == StRun) begin
        rem_q <= diff[N] ? shifted[N-1:0] : diff[N-1:0];
        dvd_q <= {dvd_q[N-2:0], ~diff[N]};
        cnt_q <= cnt_q - CntW'(1);
      end else if (state_q == StFix) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        quotient    <= q_res;
        remainder   <= r_res;
        div_by_zero <= dz_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  seq_divider #(.N(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one division and wait for done; returns clocks from accepting edge to done.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output int busy_gaps);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 32'h5a5a_a5a5; divisor = 32'h0;  // operands need not be held
    lat = 0;
    busy_gaps = (busy === 1'b1) ? 0 : 1;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (done !== 1'b1 && busy !== 1'b1) busy_gaps++;
    end
  endtask

  initial begin
    int lat, gaps, cyc, done_seen;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 33});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 33});
    vecs.push_back('{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1});
    vecs.push_back('{32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1});
    vecs.push_back('{32'h1234_5678, 32'h100, 32'h0012_3456, 32'h78, 1'b0, 33});
`else
    vecs.push_back('{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33});
    vecs.push_back('{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1});
    vecs.push_back('{32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 33});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33});
    vecs.push_back('{32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 33});
    vecs.push_back('{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 33});
    vecs.push_back('{32'h1234_5678, 32'h100, 32'h0012_3456, 32'h78, 1'b0, 33});
`endif

    // Reset state
    #12;
    check("reset_outputs", {31'b0, busy, done, div_by_zero, quotient},
          {31'b0, 1'b0, 1'b0, 1'b0, 32'h0});
    check("reset_remainder", {32'b0, remainder}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b, lat, gaps);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_busy_gaps", i), 64'(gaps), 64'h0);
      check($sformatf("v%0d_busy_at_done", i), {63'b0, busy}, 64'h0);
      check($sformatf("v%0d_quotient", i), {32'b0, quotient}, {32'b0, vecs[i].q});
      check($sformatf("v%0d_remainder", i), {32'b0, remainder}, {32'b0, vecs[i].r});
      check($sformatf("v%0d_dz", i), {63'b0, div_by_zero}, {63'b0, vecs[i].dz});
      @(posedge clk); #1;
      check($sformatf("v%0d_done_width", i), {63'b0, done}, 64'h0);
      check($sformatf("v%0d_hold_q", i), {32'b0, quotient}, {32'b0, vecs[i].q});
    end

    // 50 / 3 with a start pulse of 9 / 9 while busy, which must be ignored
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == 9);
      if (cyc == 9) begin dividend = 32'd9; divisor = 32'd9; end
    end
    start = 1'b0;
    check("busy_start_latency", 64'(cyc), 64'd33);
    check("busy_start_quotient", {32'b0, quotient}, 64'd16);
    check("busy_start_remainder", {32'b0, remainder}, 64'd2);

    // 50 / 3 aborted by reset at cycle 20
    @(negedge clk);
    start = 1'b1; dividend = 32'd50; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_busy", {63'b0, busy}, 64'h1);
    rst = 1'b1;
    #1;
    check("abort_outputs", {31'b0, busy, done, div_by_zero, quotient}, 64'h0);
    check("abort_remainder", {32'b0, remainder}, 64'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'h0);

    // Clean restart after abort
    do_div(32'd9, 32'd9, lat, gaps);
    check("restart_latency", 64'(lat), 64'd33);
    check("restart_quotient", {32'b0, quotient}, 64'd1);
    check("restart_remainder", {32'b0, remainder}, 64'd0);
    check("restart_dz", {63'b0, div_by_zero}, 64'h0);

    // Back-to-back: new start accepted while done is high
    @(negedge clk);
    start = 1'b1; dividend = 32'd20; divisor = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_busy", {63'b0, busy}, 64'h1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("b2b_quotient", {32'b0, quotient}, 64'd3);
    check("b2b_remainder", {32'b0, remainder}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
